dram_cmd_sequencer: RTL and testbench
=====================================

Name: dram_cmd_sequencer

Overview:
Sequencer directly upstream of the bit-serial DRAM bank model; sole driver of its bank_rw/buffer_rw/bank_id/rowid/colid pins and of the shared data line on writes.
Accepts whole-word host requests (valid/ready) and serialises each into bank-model cycles: 8 write-bit cycles, or row activate plus 8 read-bit cycles.
Returns read words on a valid/ready response channel.
Optionally skips the activate when the bank's row buffer already holds the requested row.

Parameters:
NUM_OF_BANKS, 8, number of banks; bank_id width = $clog2(NUM_OF_BANKS)
NUM_OF_ROWS, 128, rows per bank; rowid width = $clog2(NUM_OF_ROWS)
NUM_OF_COLS, 8, bits per row, equal to host word width; colid width = $clog2(NUM_OF_COLS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_bank  in  $clog2(NUM_OF_BANKS)  target bank
req_row  in  $clog2(NUM_OF_ROWS)  target row
req_wdata  in  NUM_OF_COLS  write word; bit c goes to column c
rsp_valid  out  1  read word available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  NUM_OF_COLS  read word; bit c from column c
wr_done  out  1  one-cycle pulse when the last write bit is issued
bank_rw  out  1  to bank model: write bank cell
buffer_rw  out  1  to bank model: 1 = load row buffer / controller owns data, 0 = bank model drives data
bank_id  out  $clog2(NUM_OF_BANKS)  to bank model
rowid  out  $clog2(NUM_OF_ROWS)  to bank model
colid  out  $clog2(NUM_OF_COLS)  to bank model
data  inout  1  bit-serial data

Behaviour:
- Reset (synchronous, active-high; applies at any point, including mid-operation): FSM goes to IDLE.
  - Outputs on reset: req_ready=0 for the reset cycle, rsp_valid=0, rsp_rdata=0, wr_done=0, bank_rw=0, buffer_rw=0, bank_id/rowid/colid=0, data released (z).
  - Open-row table is cleared.
  - Any in-flight operation is dropped without a response.
- Request latch: req_ready=1 only in IDLE. On accept, bank, row, write flag and wdata are registered.
- States: IDLE, WRITE, ACT1, ACT2, READ, DRAIN, RESP.
- IDLE: bank_rw=0, buffer_rw=0, data released. Exit: accepted write -> WRITE; accepted read -> ACT1, or -> READ on a row hit (see feature).
- WRITE: 8 cycles.
  - Drives bank_rw=1, buffer_rw=1, colid=c for c=0..7, data=wdata[c].
  - Both strobes are high so the bank model performs the bank write and does not drive data (no contention).
  - wr_done pulses in the c=7 cycle, then -> IDLE.
  - Invalidates the open-row entry of that bank.
- ACT1, ACT2: one cycle each, bank_rw=0, buffer_rw=1, bank_id/rowid held stable. Two cycles are required because the bank model copies the row to a temporary register, then to the bank buffer. ACT2 -> READ; the open-row entry is set to (bank, row, valid).
- READ: 8 cycles, bank_rw=0, buffer_rw=0, data released, colid=c for c=0..7. The bank model registers data_out one edge after colid. The bit for column c is sampled at the end of cycle c+1, so capture is pipelined one cycle behind issue.
- DRAIN: 1 cycle; samples bit 7. -> RESP.
- RESP: rsp_valid=1, rsp_rdata stable until rsp_ready. Then -> IDLE, rsp_valid=0 next cycle.
- Latencies from the accept edge:
  - write: 8 cycles to wr_done.
  - read miss: rsp_valid in cycle 12 (2 ACT + 8 READ + 1 DRAIN + 1).
  - read hit: rsp_valid in cycle 10.
- One outstanding request; no overlap.
- colid wraps 7->0 only by re-entering a state, never within one.

Optional Feature:
Macro DRAM_SEQ_ROW_HIT_EN.
- Defined: a per-bank open-row table (valid bit + row) is kept.
  - A read whose bank entry is valid with matching row goes IDLE -> READ directly.
  - Writes invalidate the written bank's entry.
  - Reset clears all entries.
- Undefined: no table; every read passes through ACT1/ACT2. Latency is always 12.

Decomposition:
- Shared package dram_pkg: state enum, NUM_OF_COLS-derived constants (ACT_CYCLES=2, READ_PIPE=1), bank/row/col index widths.
- One natural sub-module: dram_open_row_table (per-bank valid+row, lookup/set/invalidate ports). It is instantiated only under DRAM_SEQ_ROW_HIT_EN.

Test Plan:
- Reset mid-READ (assert rst at colid=3) -> next cycle buffer_rw=0, bank_rw=0, rsp_valid=0, req_ready=1 after reset release, no response issued.
- Write bank 2 row 5 word 8'hA5, then read bank 2 row 5 -> wr_done 8 cycles after accept, rsp_rdata=8'hA5 at cycle 12, bank model row matches bitwise.
- Read bank 2 row 5 again (feature on) -> no buffer_rw pulse, rsp_valid at cycle 10, data 8'hA5; feature off -> ACT1/ACT2 seen, cycle 12.
- Write bank 2 row 5 8'h3C after a hit, then read -> activate re-issued (entry invalidated), rsp_rdata=8'h3C.
- Back-to-back reads bank 0 row 127 and bank 7 row 0 with rsp_ready held low 5 cycles -> rsp_rdata stable, req_ready=0 until handshake, both words correct.
- All-banks sweep writing word {bank,row[4:0]} then reading back -> every word matches; data never driven by both sides (no X on data).

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM command sequencer and its open-row table.
// The row-hit path is enabled by DRAM_SEQ_ROW_HIT_EN.
package dram_pkg;

    localparam int DEF_BANKS  = 8;
    localparam int DEF_ROWS   = 128;
    localparam int DEF_COLS   = 8;

    localparam int BANK_W     = $clog2(DEF_BANKS);
    localparam int ROW_W      = $clog2(DEF_ROWS);
    localparam int COL_W      = $clog2(DEF_COLS);

    // Activate is two bank-model edges (row -> temp -> buffer); read data lags colid by one edge.
    localparam int ACT_CYCLES = 2;
    localparam int READ_PIPE  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_ACT1  = 3'd2,
        ST_ACT2  = 3'd3,
        ST_READ  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

endpackage

// File: rtl/dram_cmd_sequencer_open_row.sv
// Per-bank open-row table: remembers which row each bank buffer holds after an activate.
// Instantiated by dram_cmd_sequencer only when DRAM_SEQ_ROW_HIT_EN is defined.
module dram_open_row_table
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_BANKS,
    parameter int RW           = ROW_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] i_lookup_bank,
    input  logic [RW-1:0]                   i_lookup_row,
    output logic                            o_hit,
    input  logic                            i_set,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] i_set_bank,
    input  logic [RW-1:0]                   i_set_row,
    input  logic                            i_inv,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] i_inv_bank
);

    logic [NUM_OF_BANKS-1:0] r_valid;
    logic [RW-1:0]           r_row [NUM_OF_BANKS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_set) begin
                r_valid[i_set_bank] <= 1'b1;
                r_row[i_set_bank]   <= i_set_row;
            end
            if (i_inv) begin
                r_valid[i_inv_bank] <= 1'b0;
            end
        end
    end

    assign o_hit = r_valid[i_lookup_bank] && (r_row[i_lookup_bank] == i_lookup_row);

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Serialises whole-word host requests into bit-serial bank-model cycles and returns read words.
// Define DRAM_SEQ_ROW_HIT_EN to skip the activate when the bank buffer already holds the row.
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_ROWS,
    parameter int NUM_OF_COLS  = DEF_COLS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row,
    input  logic [NUM_OF_COLS-1:0]          req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NUM_OF_COLS-1:0]          rsp_rdata,
    output logic                            wr_done,
    output logic                            bank_rw,
    output logic                            buffer_rw,
    output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  rowid,
    output logic [$clog2(NUM_OF_COLS)-1:0]  colid,
    inout  wire                             data,
    output logic [2:0]                      o_dbg_state
);

    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam int CW = $clog2(NUM_OF_COLS);

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_col;
    logic [CW-1:0]        w_col_next;
    logic [BW-1:0]        r_bank;
    logic [RW-1:0]        r_row;
    logic [NUM_OF_COLS-1:0] r_wdata;
    logic [NUM_OF_COLS-1:0] r_rdata;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_hit;
    logic                 w_drive;

    assign w_accept = req_valid && req_ready;
    assign w_last   = (r_col == CW'(NUM_OF_COLS - 1));

`ifdef DRAM_SEQ_ROW_HIT_EN
    dram_open_row_table #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .RW           (RW)
    ) u_open_row (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_bank (req_bank),
        .i_lookup_row  (req_row),
        .o_hit         (w_hit),
        .i_set         (r_state == ST_ACT2),
        .i_set_bank    (r_bank),
        .i_set_row     (r_row),
        .i_inv         (r_state == ST_WRITE),
        .i_inv_bank    (r_bank)
    );
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        case (r_state)
            ST_IDLE: begin
                w_col_next = '0;
                if (w_accept) begin
                    if (req_write)  w_state_next = ST_WRITE;
                    else if (w_hit) w_state_next = ST_READ;
                    else            w_state_next = ST_ACT1;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                    w_col_next   = '0;
                end else begin
                    w_col_next = r_col + CW'(1);
                end
            end
            ST_ACT1: w_state_next = ST_ACT2;
            ST_ACT2: begin
                w_state_next = ST_READ;
                w_col_next   = '0;
            end
            ST_READ: begin
                // colid holds at the last column through DRAIN; it only restarts on state entry.
                if (w_last) w_state_next = ST_DRAIN;
                else        w_col_next   = r_col + CW'(1);
            end
            ST_DRAIN: w_state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the registered state and forced idle while reset is asserted.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        wr_done   = 1'b0;
        bank_rw   = 1'b0;
        buffer_rw = 1'b0;
        bank_id   = '0;
        rowid     = '0;
        colid     = '0;
        w_drive   = 1'b0;
        if (!rst) begin
            bank_id = r_bank;
            rowid   = r_row;
            colid   = r_col;
            case (r_state)
                ST_IDLE: req_ready = 1'b1;
                ST_WRITE: begin
                    bank_rw   = 1'b1;
                    buffer_rw = 1'b1;
                    w_drive   = 1'b1;
                    wr_done   = w_last;
                end
                ST_ACT1, ST_ACT2: buffer_rw = 1'b1;
                ST_RESP: rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign data        = w_drive ? r_wdata[r_col] : 1'bz;
    assign rsp_rdata   = rst ? '0 : r_rdata;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_bank  <= '0;
            r_row   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            if (w_accept) begin
                r_bank  <= req_bank;
                r_row   <= req_row;
                r_wdata <= req_wdata;
            end
            // Capture runs READ_PIPE columns behind issue; DRAIN picks up the final bit.
            if (r_state == ST_READ && r_col >= CW'(READ_PIPE)) begin
                r_rdata[r_col - CW'(READ_PIPE)] <= data;
            end
            if (r_state == ST_DRAIN) begin
                r_rdata[NUM_OF_COLS-1] <= data;
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer with a bit-serial bank model and a word-level reference model.
module tb_dram_cmd_sequencer;
    import dram_pkg::*;

    localparam int NB       = DEF_BANKS;
    localparam int NR       = DEF_ROWS;
    localparam int NC       = DEF_COLS;
    localparam int HIT_LAT  = NC + READ_PIPE + 1;
    localparam int MISS_LAT = ACT_CYCLES + HIT_LAT;
`ifdef DRAM_SEQ_ROW_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [BANK_W-1:0] req_bank  = '0;
    logic [ROW_W-1:0]  req_row   = '0;
    logic [NC-1:0]     req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [NC-1:0]     rsp_rdata;
    logic              wr_done;
    logic              bank_rw;
    logic              buffer_rw;
    logic [BANK_W-1:0] bank_id;
    logic [ROW_W-1:0]  rowid;
    logic [COL_W-1:0]  colid;
    wire               data;
    logic [2:0]        dbg_state;

    dram_cmd_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_bank    (req_bank),
        .req_row     (req_row),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .wr_done     (wr_done),
        .bank_rw     (bank_rw),
        .buffer_rw   (buffer_rw),
        .bank_id     (bank_id),
        .rowid       (rowid),
        .colid       (colid),
        .data        (data),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bit-serial bank model ----------------
    logic [NC-1:0] bank_mem [NB][NR];
    logic [NC-1:0] bank_tmp [NB];
    logic [NC-1:0] bank_buf [NB];
    logic          bank_dout = 1'b0;

    assign data = buffer_rw ? 1'bz : bank_dout;

    initial begin
        for (int b = 0; b < NB; b++) begin
            bank_tmp[b] = '0;
            bank_buf[b] = '0;
            for (int r = 0; r < NR; r++) bank_mem[b][r] = '0;
        end
    end

    always @(posedge clk) begin
        if (buffer_rw && bank_rw) begin
            bank_mem[bank_id][rowid][colid] <= data;
        end else if (buffer_rw) begin
            bank_tmp[bank_id] <= bank_mem[bank_id][rowid];
            bank_buf[bank_id] <= bank_tmp[bank_id];
        end
        bank_dout <= bank_buf[bank_id][colid];
    end

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- response-ready driver ----------------
    bit rsp_block = 1'b0;
    bit rsp_rand  = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = !rsp_block && (rsp_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [NC-1:0]    mdl_mem  [NB][NR];
    bit               mdl_ov   [NB];
    logic [ROW_W-1:0] mdl_orow [NB];
    logic [NC-1:0]    exp_q[$];

    initial begin : compare
        bit               busy;
        bit               m_wr;
        int               acc;
        int               m_lat;
        int               k;
        int               off;
        logic [BANK_W-1:0] m_bank;
        logic [ROW_W-1:0]  m_row;
        logic [NC-1:0]     m_wdata;
        bit               e_brw, e_bfr, e_wrd, e_rv, hit;
        busy = 1'b0; m_wr = 1'b0; acc = 0; m_lat = MISS_LAT;
        m_bank = '0; m_row = '0; m_wdata = '0;
        for (int b = 0; b < NB; b++) begin
            mdl_ov[b]   = 1'b0;
            mdl_orow[b] = '0;
            for (int r = 0; r < NR; r++) mdl_mem[b][r] = '0;
        end
        forever begin
            @(negedge clk);
            chk("data_no_contention", {31'd0, data === 1'bx}, 32'd0);
            if (rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_wr_done",   wr_done, 0);
                chk("rst_bank_rw",   bank_rw, 0);
                chk("rst_buffer_rw", buffer_rw, 0);
                chk("rst_bank_id",   bank_id, 0);
                chk("rst_rowid",     rowid, 0);
                chk("rst_colid",     colid, 0);
                busy = 1'b0;
                exp_q.delete();
                for (int b = 0; b < NB; b++) mdl_ov[b] = 1'b0;
            end else begin
                k = cyc - acc;
                e_brw = 1'b0; e_bfr = 1'b0; e_wrd = 1'b0; e_rv = 1'b0;
                if (busy && m_wr) begin
                    if (k >= 1 && k <= NC) begin
                        e_brw = 1'b1;
                        e_bfr = 1'b1;
                        e_wrd = (k == NC);
                        chk("wr_colid", colid, k - 1);
                        chk("wr_bank_id", bank_id, m_bank);
                        chk("wr_rowid", rowid, m_row);
                        chk("wr_data_bit", {31'd0, data === m_wdata[k-1]}, 32'd1);
                    end
                end else if (busy) begin
                    off = m_lat - HIT_LAT;
                    if (k >= 1 && k <= off) begin
                        e_bfr = 1'b1;
                        chk("act_bank_id", bank_id, m_bank);
                        chk("act_rowid", rowid, m_row);
                    end else if (k > off && k <= off + NC) begin
                        chk("rd_colid", colid, k - off - 1);
                        chk("rd_bank_id", bank_id, m_bank);
                    end
                    e_rv = (k >= m_lat);
                end
                chk("req_ready", req_ready, !busy);
                chk("bank_rw",   bank_rw, e_brw);
                chk("buffer_rw", buffer_rw, e_bfr);
                chk("wr_done",   wr_done, e_wrd);
                chk("rsp_valid", rsp_valid, e_rv);
                if (e_rv && exp_q.size() > 0) chk("rsp_rdata", rsp_rdata, exp_q[0]);

                if (busy && m_wr && k == NC) begin
                    mdl_mem[m_bank][m_row] = m_wdata;
                    busy = 1'b0;
                end else if (busy && !m_wr && k >= m_lat && rsp_ready) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end else if (!busy && req_valid) begin
                    busy = 1'b1;
                    acc = cyc;
                    m_wr = req_write;
                    m_bank = req_bank;
                    m_row = req_row;
                    m_wdata = req_wdata;
                    if (m_wr) begin
                        mdl_ov[m_bank] = 1'b0;
                    end else begin
                        hit = HIT_EN && mdl_ov[m_bank] && (mdl_orow[m_bank] == m_row);
                        m_lat = hit ? HIT_LAT : MISS_LAT;
                        mdl_ov[m_bank] = 1'b1;
                        mdl_orow[m_bank] = m_row;
                        exp_q.push_back(mdl_mem[m_bank][m_row]);
                        chk("bank_model_row", bank_mem[m_bank][m_row], mdl_mem[m_bank][m_row]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input bit w, input int b, input int r, input int d, output int t_acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_bank  = BANK_W'(b);
        req_row   = ROW_W'(r);
        req_wdata = NC'(d);
        t_acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) chk("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_wr(input int t_acc, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_done) begin
                lat = cyc - t_acc;
                break;
            end
        end
        if (lat < 0) chk("wr_done_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int t_acc, output int lat, output logic [NC-1:0] word, output int acts);
        lat = -1;
        acts = 0;
        word = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (buffer_rw && !bank_rw) acts++;
            if (rsp_valid) begin
                lat = cyc - t_acc;
                word = rsp_rdata;
                break;
            end
        end
        if (lat < 0) chk("rsp_timeout", 0, 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : main
        int            ta, lat, acts, row;
        logic [NC-1:0] word, wd;
        bit            hit_seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        // write then read-miss of bank 2 row 5
        do_req(1'b1, 2, 5, 8'hA5, ta);
        wait_wr(ta, lat);
        chk("wr_latency", lat, 8);
        do_req(1'b0, 2, 5, 0, ta);
        wait_rsp(ta, lat, word, acts);
        chk("miss_latency", lat, 12);
        chk("miss_acts", acts, 2);
        chk("miss_word", word, 8'hA5);

        // repeated read: row hit when the table is built in
        do_req(1'b0, 2, 5, 0, ta);
        wait_rsp(ta, lat, word, acts);
        chk("reread_latency", lat, HIT_EN ? 10 : 12);
        chk("reread_acts", acts, HIT_EN ? 0 : 2);
        chk("reread_word", word, 8'hA5);

        // write after hit must force a fresh activate
        do_req(1'b1, 2, 5, 8'h3C, ta);
        wait_wr(ta, lat);
        do_req(1'b0, 2, 5, 0, ta);
        wait_rsp(ta, lat, word, acts);
        chk("post_wr_latency", lat, 12);
        chk("post_wr_acts", acts, 2);
        chk("post_wr_word", word, 8'h3C);

        // back-to-back reads with a stalled response
        do_req(1'b1, 0, 127, 8'h5A, ta);
        wait_wr(ta, lat);
        do_req(1'b1, 7, 0, 8'hC3, ta);
        wait_wr(ta, lat);
        rsp_block = 1'b1;
        do_req(1'b0, 0, 127, 0, ta);
        wait_rsp(ta, lat, word, acts);
        chk("b2b_word0", word, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b2b_hold_ready", req_ready, 0);
            chk("b2b_hold_valid", rsp_valid, 1);
            chk("b2b_hold_rdata", rsp_rdata, 8'h5A);
        end
        rsp_block = 1'b0;
        do_req(1'b0, 7, 0, 0, ta);
        wait_rsp(ta, lat, word, acts);
        chk("b2b_word1", word, 8'hC3);

        // reset in the middle of a read, at colid 3
        do_req(1'b0, 3, 9, 0, ta);
        hit_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!buffer_rw && !bank_rw && colid == 3 && !rsp_valid) begin
                hit_seen = 1'b1;
                break;
            end
        end
        chk("reached_colid3", hit_seen, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_buffer_rw", buffer_rw, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end

        // all-banks sweep
        for (int b = 0; b < NB; b++) begin
            row = b * 16 + 5;
            wd = {BANK_W'(b), 5'(row)};
            do_req(1'b1, b, row, wd, ta);
            wait_wr(ta, lat);
        end
        for (int b = 0; b < NB; b++) begin
            row = b * 16 + 5;
            wd = {BANK_W'(b), 5'(row)};
            do_req(1'b0, b, row, 0, ta);
            wait_rsp(ta, lat, word, acts);
            chk("sweep_word", word, wd);
        end

        // randomized mix over a few rows so hits and invalidations occur
        rsp_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            do_req($urandom_range(0, 1) == 1, $urandom_range(0, NB - 1),
                   $urandom_range(0, 3), $urandom_range(0, 255), ta);
        end
        rsp_rand = 1'b0;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_err++;
        $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
